beat_record_controller: RTL

- Top-level sequencer for the beat RAM: one FSM owns the single-port RAM address, write enable and write data.
- Records keystroke changes into consecutive addresses, stores the recorded length, then plays the recording back one address per tick, looping.
- Replaces free-running store/load address counters with one arbitrated controller between keyboard decoder, RAM and display/audio.

---
 rtl/beat_pkg.sv | 17 +
 rtl/beat_tick_divider.sv | 34 +++
 rtl/beat_record_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/beat_pkg.sv
// Shared definitions for the beat RAM sequencer: FSM state encodings and
// default widths / idle key code used by the controller and its testbench.
package beat_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 7;

  // ASCII space: the keyboard decoder's "no key pressed" code.
  localparam logic [DEF_DATA_W-1:0] DEF_IDLE_CHAR = 7'd32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/beat_tick_divider.sv
// Playback step divider: counts TICK_DIV-1 down to 0, pulses tick for one
// cycle when the count is 0 and reloads. clear restarts a full period.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : reload TICK_DIV-1 (suppresses tick this cycle)
//   tick       : one-cycle pulse every TICK_DIV cycles
module beat_tick_divider #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Down counter with reload on zero or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (clear || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/beat_record_controller.sv
// Beat RAM sequencer: a single FSM owns the RAM address, write enable and
// write data. RECORD writes each key change to consecutive addresses and
// stores the length; PLAY steps through the recording once per tick, looping.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rec_start/play_start  : one-cycle command pulses (stop has priority,
//   stop                  :   then rec_start, then play_start)
//   ascii                 : current key code from keyboard decoder
//   ram_q                 : RAM read data (1-cycle registered read)
//   ram_addr/data/wren    : RAM control
//   play_ascii            : key code being played (idle code otherwise)
//   rec_len               : number of stored entries, 0..2**ADDR_W
//   state                 : 0=IDLE, 1=RECORD, 2=PLAY
module beat_record_controller
  import beat_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned TICK_DIV = 50000000,
  parameter logic [DATA_W-1:0] IDLE_CHAR = DATA_W'(DEF_IDLE_CHAR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic [DATA_W-1:0] ascii,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [DATA_W-1:0] play_ascii,
  output logic [ADDR_W:0]   rec_len,
  output logic [1:0]        state
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state_q, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [DATA_W-1:0] prev_ascii, prev_ascii_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_data_nxt;
  logic              ram_wren_nxt;
  logic [DATA_W-1:0] play_ascii_nxt;
  logic [PTR_W-1:0]  rec_len_nxt;
  logic [PTR_W-1:0]  rd_inc;
  logic              full;
  logic              div_clear;
  logic              tick;

  beat_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  // rd_inc is one bit wider than rd_ptr so it can equal a full-depth rec_len.
  assign rd_inc = PTR_W'(rd_ptr) + PTR_W'(1);
  assign full   = (wr_ptr == PTR_W'(DEPTH));
  assign state  = state_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prev_ascii <= IDLE_CHAR;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      play_ascii <= IDLE_CHAR;
      rec_len    <= '0;
    end else begin
      state_q    <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      prev_ascii <= prev_ascii_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_data   <= ram_data_nxt;
      ram_wren   <= ram_wren_nxt;
      play_ascii <= play_ascii_nxt;
      rec_len    <= rec_len_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state_q;
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    prev_ascii_nxt = prev_ascii;
    ram_addr_nxt   = ram_addr;
    ram_data_nxt   = ram_data;
    ram_wren_nxt   = 1'b0;
    play_ascii_nxt = play_ascii;
    rec_len_nxt    = rec_len;
    div_clear      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ram_addr_nxt   = '0;
        play_ascii_nxt = IDLE_CHAR;
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (rec_start) begin
          state_nxt      = ST_RECORD;
          wr_ptr_nxt     = '0;
          prev_ascii_nxt = IDLE_CHAR;
        end else if (play_start && (rec_len != '0)) begin
          state_nxt    = ST_PLAY;
          rd_ptr_nxt   = '0;
          ram_addr_nxt = '0;
          div_clear    = 1'b1;
        end
      end

      ST_RECORD: begin
        play_ascii_nxt = IDLE_CHAR;
        // A full buffer ends the recording on its own; no wrap.
        if (stop || full) begin
          state_nxt    = ST_IDLE;
          rec_len_nxt  = wr_ptr;
          ram_addr_nxt = '0;
        end else if (ascii != prev_ascii) begin
          ram_wren_nxt   = 1'b1;
          ram_addr_nxt   = wr_ptr[ADDR_W-1:0];
          ram_data_nxt   = ascii;
          wr_ptr_nxt     = wr_ptr + PTR_W'(1);
          prev_ascii_nxt = ascii;
        end
      end

      ST_PLAY: begin
        play_ascii_nxt = ram_q;
        if (stop) begin
          state_nxt      = ST_IDLE;
          ram_addr_nxt   = '0;
          play_ascii_nxt = IDLE_CHAR;
        end else if (rec_start) begin
          state_nxt      = ST_RECORD;
          wr_ptr_nxt     = '0;
          prev_ascii_nxt = IDLE_CHAR;
        end else if (play_start) begin
          rd_ptr_nxt   = '0;
          ram_addr_nxt = '0;
          div_clear    = 1'b1;
        end else if (tick) begin
          rd_ptr_nxt   = (rd_inc == rec_len) ? '0 : rd_inc[ADDR_W-1:0];
          ram_addr_nxt = rd_ptr_nxt;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
